if_stage_fq: RTL and testbench
==============================

Name: if_stage_fq

Overview:
- Next-generation fetch stage. Owns the PC register and issues in-order requests to a variable-latency instruction memory.
- Buffers returned instructions in a parametrised fetch queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirect with in-flight response squashing (epoch tag). Sits between the PC-select logic (EX redirect) and the IF/ID boundary.

Parameters:
- XLEN, 32, datapath and address width
- FQ_DEPTH, 4, fetch-queue entries (power of 2, >=2); also the cap on outstanding requests
- RESET_VECTOR, 32'h0000_0000, PC value after reset

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- redirect_i  in  1  taken branch/jump from EX
- redirect_pc_i  in  XLEN  redirect target
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  XLEN  fetch address (PC)
- imem_rsp_valid_i  in  1  response valid (in order, no backpressure)
- imem_rsp_data_i  in  32  instruction word
- id_valid_o  out  1  decode entry valid
- id_ready_i  in  1  decode accepts (low = StallD)
- id_o  out  ifid_t  {instr, PC, PCPlus4} of queue head
- pcplus4_o  out  XLEN  PC+4 of the current fetch PC (to PC mux)

Behaviour:
- Reset (async assert, sync release): PC=RESET_VECTOR, queue empty, outstanding=0, epoch=0. id_valid_o=0, imem_req_valid_o=0, id_o=0.
- Request issue: imem_req_valid_o = (count + outstanding < FQ_DEPTH) && !redirect_i.
  - On req handshake: the pending table records {PC, epoch}, outstanding++, PC <= PC+4 (modulo 2^XLEN, wraps silently).
- Pending table: FIFO of FQ_DEPTH {PC, epoch}. Responses pop it in order.
  - Response epoch == current epoch: push {instr, PC, PC+4} into the fetch queue.
  - Otherwise: discard.
  - Either way outstanding--.
- Decode handshake: pop on id_valid_o && id_ready_i. id_o is driven from the queue head (combinational, zero added latency).
- Best-case latency: request cycle N, response N+k, id_valid_o in the same cycle the entry is written +1 (queue is registered).
- Full: count + outstanding == FQ_DEPTH blocks new requests. Space is guaranteed for every outstanding response.
- Empty: id_valid_o=0. No bypass from response to id_o.
- Same-cycle push and pop: legal at any occupancy, including full (count unchanged).
- Redirect (one cycle pulse, highest priority):
  - PC <= redirect_pc_i, epoch toggles, fetch queue cleared.
  - No request issued that cycle.
  - A decode pop in the same cycle is still reported to decode as accepted; decode flushes it itself.
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: each toggles epoch. Stale responses are those whose tag != epoch.
  - Outstanding <= FQ_DEPTH and responses are in order, so a 1-bit epoch is sufficient only if one redirect cycle separates epochs. Therefore the epoch is ceil(log2(FQ_DEPTH))+1 bits, incrementing.
- Misaligned redirect_pc_i[1:0]!=0: forced to 0 (low bits masked).
- pcplus4_o = PC+4 at all times.

Optional Feature:
- IF_PERF_CNT_EN defined: adds 32-bit saturating counters fetched_cnt (responses accepted into the queue), squashed_cnt (stale responses discarded), stall_cnt (cycles id_valid_o && !id_ready_i). All reset to 0. Exposed on output ports perf_fetched_o, perf_squashed_o, perf_stall_o.
- IF_PERF_CNT_EN undefined: counters and ports are absent; functional behaviour is identical.

Decomposition:
- pipeline_pkg: reuse ifid_t. Add fetch_tag_t {PC, epoch} and FQ_DEPTH_DEFAULT.
- One sub-module: fetch_fifo. Generic sync FIFO, parametrised on type/depth, with push/pop/clear/count. Instantiated twice: pending table and fetch queue.

Test Plan:
- Reset, mem latency 1, id_ready_i=1 -> addresses 0,4,8,… issued every cycle. id_o.PC 0,4,8 with PCPlus4 4,8,12. Steady-state throughput 1/cycle.
- id_ready_i=0 for 10 cycles -> exactly 4 requests issued then imem_req_valid_o=0. On release, PCs 0..12 delivered in order with no loss or duplication.
- Mem latency 3, redirect_i to 0x100 with 3 responses in flight -> the 3 stale responses are dropped (squashed_cnt=3 if enabled). The first id_o.PC after the redirect is 0x100.
- Redirects to 0x200 then 0x300 on consecutive cycles -> no entry with PC 0x200 is ever delivered. First delivered PC is 0x300.
- PC=32'hFFFF_FFFC fetched -> next request address is 0x0, PCPlus4=0x0.
- rst_n asserted mid-burst with queue full -> id_valid_o and imem_req_valid_o drop immediately. After release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the fetch stage: IF/ID payload, the fetch
// request tag, and default sizing constants.
package pipeline_pkg;

  localparam int IFID_XLEN        = 32;
  localparam int FQ_DEPTH_DEFAULT = 4;
  // Increments on every redirect; the extra bit over log2(depth) covers
  // back-to-back redirects while responses are still in flight.
  localparam int EPOCH_W          = $clog2(FQ_DEPTH_DEFAULT) + 1;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pc_plus4;
  } ifid_t;

  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [EPOCH_W-1:0]   epoch;
  } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push/pop/clear and occupancy count.
// Push while full is accepted only when a pop happens in the same cycle;
// clear has priority over push and pop.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  output T                         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  T                mem_q [DEPTH];
  T                mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  // Next-state for storage, pointers and count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_stage_fq.sv
// Fetch stage: PC register, in-order requests to a variable-latency imem,
// pending-tag table plus fetch queue, and epoch-based squashing on redirect.
// Optional macro IF_PERF_CNT_EN adds saturating performance counters.
// The IF/ID payload type is fixed at 32-bit addresses and the epoch is sized
// for FQ_DEPTH_DEFAULT entries.
module if_stage_fq
  import pipeline_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FQ_DEPTH     = FQ_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output ifid_t           id_o,
  output logic [XLEN-1:0] pcplus4_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_squashed_o,
  output logic [31:0]     perf_stall_o
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [CW-1:0]      fq_count, pend_count;
  logic [CW:0]        occupancy;
  fetch_tag_t         pend_tag, pend_head;
  ifid_t              fq_entry, fq_head;
  logic               req_valid, req_hs, rsp_accept, rsp_stale, id_valid, id_pop;

  // Request gating, response classification and next PC/epoch.
  always_comb begin
    occupancy  = (CW+1)'(fq_count) + (CW+1)'(pend_count);
    req_valid  = rst_n && !redirect_i && (occupancy < (CW+1)'(FQ_DEPTH));
    req_hs     = req_valid && imem_req_ready_i;
    rsp_accept = imem_rsp_valid_i && !redirect_i && (pend_head.epoch == epoch_q);
    rsp_stale  = imem_rsp_valid_i && !rsp_accept;
    id_valid   = (fq_count != '0);
    id_pop     = id_valid && id_ready_i;

    pend_tag.pc       = pc_q;
    pend_tag.epoch    = epoch_q;
    fq_entry.instr    = imem_rsp_data_i;
    fq_entry.pc       = pend_head.pc;
    fq_entry.pc_plus4 = pend_head.pc + XLEN'(4);

    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redirect_i) begin
      pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
      epoch_d = epoch_q + 1'b1;
    end else if (req_hs) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // PC and epoch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      epoch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  fetch_fifo #(.T(fetch_tag_t), .DEPTH(FQ_DEPTH)) u_pending (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_hs),
    .data_i  (pend_tag),
    .pop_i   (imem_rsp_valid_i),
    .clear_i (1'b0),
    .data_o  (pend_head),
    .count_o (pend_count)
  );

  fetch_fifo #(.T(ifid_t), .DEPTH(FQ_DEPTH)) u_fetch_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_accept),
    .data_i  (fq_entry),
    .pop_i   (id_pop),
    .clear_i (redirect_i),
    .data_o  (fq_head),
    .count_o (fq_count)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc_q;
  assign id_valid_o       = id_valid;
  assign id_o             = fq_head;
  assign pcplus4_o        = pc_q + XLEN'(4);

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetched_cnt_q, fetched_cnt_d;
  logic [31:0] squashed_cnt_q, squashed_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating event counters.
  always_comb begin
    fetched_cnt_d  = fetched_cnt_q;
    squashed_cnt_d = squashed_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (rsp_accept && (fetched_cnt_q != '1))            fetched_cnt_d  = fetched_cnt_q + 1'b1;
    if (rsp_stale && (squashed_cnt_q != '1))            squashed_cnt_d = squashed_cnt_q + 1'b1;
    if (id_valid && !id_ready_i && (stall_cnt_q != '1)) stall_cnt_d    = stall_cnt_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_cnt_q  <= '0;
      squashed_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetched_cnt_q  <= fetched_cnt_d;
      squashed_cnt_q <= squashed_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign perf_fetched_o  = fetched_cnt_q;
  assign perf_squashed_o = squashed_cnt_q;
  assign perf_stall_o    = stall_cnt_q;
`else
  logic unused_stale;
  assign unused_stale = rsp_stale;
`endif

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: queue-based behavioural model, fixed-latency
// memory responder, per-cycle comparison and directed scenarios.
module tb_if_stage_fq;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        id_valid_o;
  logic        id_ready_i;
  ifid_t       id_o;
  logic [31:0] pcplus4_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_squashed_o, perf_stall_o;
`endif

  always #5 clk = ~clk;

  if_stage_fq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_ready_i       (id_ready_i),
    .id_o             (id_o),
    .pcplus4_o        (pcplus4_o)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched_o   (perf_fetched_o),
    .perf_squashed_o  (perf_squashed_o),
    .perf_stall_o     (perf_stall_o)
`endif
  );

  typedef struct { logic [31:0] pc; int epoch; } tag_s;
  typedef struct { logic [31:0] addr; int due; } mreq_s;

  logic [31:0] m_pc;
  int          m_epoch;
  tag_s        m_pend[$];
  ifid_t       m_fq[$];
  ifid_t       delivered[$];
  int          m_fetched, m_squashed, m_stall;
  mreq_s       mem_q[$];
  int          mem_lat;
  int          cyc;
  int          req_seen;
  int          checks;
  int          failures;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 32'h0;
    m_epoch = 0;
    m_pend.delete();
    m_fq.delete();
    delivered.delete();
    mem_q.delete();
    m_fetched = 0;
    m_squashed = 0;
    m_stall = 0;
  endtask

  task automatic doReset(input int lat);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = 32'h0;
    modelReset();
    mem_lat = lat;
    #1;
    checkOutput("reset_id_valid", id_valid_o, 0);
    checkOutput("reset_req_valid", imem_req_valid_o, 0);
    checkOutput("reset_id_pc", id_o.pc, 0);
    checkOutput("reset_id_instr", id_o.instr, 0);
    checkOutput("reset_addr", imem_req_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs, compare outputs with the model, advance model.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc,
                               input logic rdy, input logic mrdy);
    logic  exp_req;
    tag_s  t;
    ifid_t e;
    @(negedge clk);
    redirect_i = redir;
    redirect_pc_i = rpc;
    id_ready_i = rdy;
    imem_req_ready_i = mrdy;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i = 32'h0;
    end
    #1;
    exp_req = ((m_fq.size() + m_pend.size()) < 4) && !redir;
    checkOutput("req_valid", imem_req_valid_o, exp_req);
    if (exp_req) checkOutput("req_addr", imem_req_addr_o, m_pc);
    checkOutput("pcplus4", pcplus4_o, m_pc + 32'd4);
    checkOutput("id_valid", id_valid_o, m_fq.size() > 0);
    if (m_fq.size() > 0) begin
      checkOutput("id_instr", id_o.instr, m_fq[0].instr);
      checkOutput("id_pc", id_o.pc, m_fq[0].pc);
      checkOutput("id_pcplus4", id_o.pc_plus4, m_fq[0].pc_plus4);
    end
    if (imem_req_valid_o && mrdy) begin
      mem_q.push_back('{imem_req_addr_o, cyc + mem_lat});
      req_seen++;
    end
    if (m_fq.size() > 0 && !rdy) m_stall++;
    if (redir) begin
      if (imem_rsp_valid_i && m_pend.size() > 0) begin
        t = m_pend.pop_front();
        m_squashed++;
      end
      m_pc = {rpc[31:2], 2'b00};
      m_epoch++;
      m_fq.delete();
    end else begin
      if (rdy && m_fq.size() > 0) begin
        e = m_fq.pop_front();
        delivered.push_back(e);
      end
      if (imem_rsp_valid_i && m_pend.size() > 0) begin
        t = m_pend.pop_front();
        if (t.epoch == m_epoch) begin
          e.instr = mem_word(t.pc);
          e.pc = t.pc;
          e.pc_plus4 = t.pc + 32'd4;
          m_fq.push_back(e);
          m_fetched++;
        end else begin
          m_squashed++;
        end
      end
      if (exp_req && mrdy) begin
        m_pend.push_back('{m_pc, m_epoch});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    int idx;
    int sq0;
    logic found;
    checks = 0;
    failures = 0;
    cyc = 0;
    req_seen = 0;
    rst_n = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    id_ready_i = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i = 32'h0;
    modelReset();
    mem_lat = 1;

    // Streaming at latency 1: one delivery per cycle from the third cycle.
    $display("[TB] streaming, latency 1");
    doReset(1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("stream_count", delivered.size(), 10);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stream_pc", delivered[i].pc, 32'(i * 4));
      checkOutput("stream_pcplus4", delivered[i].pc_plus4, 32'(i * 4 + 4));
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, (i % 3) != 0, (i % 4) != 1);

    // Decode stalled: only FQ_DEPTH requests go out, then drain in order.
    $display("[TB] decode stall");
    doReset(1);
    req_seen = 0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("stall_reqs", req_seen, 4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) checkOutput("stall_drain_pc", delivered[i].pc, 32'(i * 4));
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_stall", perf_stall_o, m_stall);
`endif

    // Redirect with three responses in flight at latency 3.
    $display("[TB] redirect with in-flight responses");
    doReset(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    sq0 = m_squashed;
    idx = delivered.size();
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("squash_count", m_squashed - sq0, 3);
    checkOutput("redir_first_pc", delivered[idx].pc, 32'h100);
`ifdef IF_PERF_CNT_EN
    checkOutput("perf_squashed", perf_squashed_o, 3);
    checkOutput("perf_fetched", perf_fetched_o, m_fetched);
`endif

    // Back-to-back redirects: the first target is never delivered.
    $display("[TB] back-to-back redirects");
    doReset(1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    idx = delivered.size();
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("b2b_first_pc", delivered[idx].pc, 32'h300);
    found = 1'b0;
    foreach (delivered[i]) if (delivered[i].pc == 32'h200) found = 1'b1;
    checkOutput("b2b_no_0x200", found, 0);

    // Misaligned redirect near the top of the address space, then wrap.
    $display("[TB] address wrap");
    doReset(1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    checkOutput("wrap_masked_pc", m_pc, 32'hFFFF_FFFC);
    idx = delivered.size();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_next_pc", m_pc, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("wrap_pc", delivered[idx].pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pcplus4", delivered[idx].pc_plus4, 32'h0);
    checkOutput("wrap_after_pc", delivered[idx + 1].pc, 32'h0);

    // Asynchronous reset mid-burst with the queue full.
    $display("[TB] reset mid-burst");
    doReset(1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("full_before_reset", m_fq.size(), 4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_id_valid", id_valid_o, 0);
    checkOutput("async_req_valid", imem_req_valid_o, 0);
    doReset(1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("restart_pc", delivered[0].pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
